// File: rtl/wrapped_project_select_if.sv
// wrapped_project_select_if: Wishbone classic slave bundle carrying the
// strobe/cycle/write/select/address/data lines and the ack/read-data returns.
interface wrapped_project_select_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   input  wbs_ack_o, wbs_dat_o);
   modport slave  (input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
                   output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wrapped_project_select.sv
// wrapped_project_select: Wishbone-programmed break-before-make scheduler that
// drives the one-hot active enables of the wrapped user projects.
module wrapped_project_select #(
   parameter int          NUM_PROJECTS = 8,
   parameter int          GUARD_RESET  = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   wrapped_project_select_if.slave     wb,
   output logic [NUM_PROJECTS-1:0]     active_o,
   output logic                        busy_o,
   output logic                        irq_o
);
   localparam int SEL_W = $clog2(NUM_PROJECTS);
   localparam logic [NUM_PROJECTS-1:0] ONE = 1;
   typedef enum logic [1:0] {IDLE, DRAIN, ENGAGE} state_t;
   state_t                  state_q, state_d;
   logic                    ack_q, ack_d;
   logic [31:0]             dat_q, dat_d;
   logic [SEL_W-1:0]        ctl_sel_q, ctl_sel_d, run_sel_q, run_sel_d, cur_sel_q, cur_sel_d;
   logic                    ctl_en_q, ctl_en_d, ctl_irq_q, ctl_irq_d;
   logic                    run_en_q, run_en_d, run_irq_q, run_irq_d;
   logic                    valid_q, valid_d, done_q, done_d, req_q, req_d, irq_q, irq_d;
   logic [7:0]              guard_q, guard_d, cnt_q, cnt_d;
   logic [15:0]             count_q, count_d;
   logic [NUM_PROJECTS-1:0] active_q, active_d;
   logic                    hit, wr, load, engage, unused_bits;
   logic [1:0]              off;
   logic [31:0]             rdata;
   assign hit    = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q && wb.wbs_adr_i[31:4] == BASE_ADDR[31:4];
   assign wr     = hit && wb.wbs_we_i;
   assign off    = wb.wbs_adr_i[3:2];
   // req_q doubles as the single pending slot; IDLE and the ENGAGE cycle both consume it
   assign load   = (state_q == IDLE || state_q == ENGAGE) && req_q;
   assign engage = state_q == DRAIN && cnt_q == 8'd1;
   assign busy_o = state_q != IDLE;
   assign active_o = active_q;
   assign irq_o  = irq_q;
   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;
   assign unused_bits = ^{wb.wbs_dat_i[31:11], wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:2]};
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q   <= IDLE;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         ctl_sel_q <= '0;
         ctl_en_q  <= 1'b0;
         ctl_irq_q <= 1'b0;
         run_sel_q <= '0;
         run_en_q  <= 1'b0;
         run_irq_q <= 1'b0;
         cur_sel_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         irq_q     <= 1'b0;
         guard_q   <= 8'(GUARD_RESET);
         cnt_q     <= '0;
         count_q   <= '0;
         active_q  <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         ctl_sel_q <= ctl_sel_d;
         ctl_en_q  <= ctl_en_d;
         ctl_irq_q <= ctl_irq_d;
         run_sel_q <= run_sel_d;
         run_en_q  <= run_en_d;
         run_irq_q <= run_irq_d;
         cur_sel_q <= cur_sel_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         req_q     <= req_d;
         irq_q     <= irq_d;
         guard_q   <= guard_d;
         cnt_q     <= cnt_d;
         count_q   <= count_d;
         active_q  <= active_d;
      end
   end
   always_comb begin
      state_d = load ? DRAIN : engage ? ENGAGE : state_q == ENGAGE ? IDLE : state_q;
   end
   always_comb begin
      rdata = off == 2'd0 ? {22'b0, ctl_irq_q, ctl_en_q, 8'(ctl_sel_q)} :
              off == 2'd1 ? {21'b0, done_q, busy_o, valid_q, 8'(cur_sel_q)} :
              off == 2'd2 ? {24'b0, guard_q} : {16'b0, count_q};
      ack_d     = hit;
      dat_d     = hit && !wb.wbs_we_i ? rdata : 32'b0;
      ctl_sel_d = wr && off == 2'd0 && wb.wbs_sel_i[0] ? wb.wbs_dat_i[SEL_W-1:0] : ctl_sel_q;
      ctl_en_d  = wr && off == 2'd0 && wb.wbs_sel_i[1] ? wb.wbs_dat_i[8] : ctl_en_q;
      ctl_irq_d = wr && off == 2'd0 && wb.wbs_sel_i[1] ? wb.wbs_dat_i[9] : ctl_irq_q;
      guard_d   = wr && off == 2'd2 && wb.wbs_sel_i[0] ? wb.wbs_dat_i[7:0] : guard_q;
      req_d     = (wr && off == 2'd0) || (req_q && !load);
      done_d    = engage ? 1'b1 : wr && off == 2'd1 && wb.wbs_sel_i[1] && wb.wbs_dat_i[10] ? 1'b0 : done_q;
      run_sel_d = load ? ctl_sel_q : run_sel_q;
      run_en_d  = load ? ctl_en_q : run_en_q;
      run_irq_d = load ? ctl_irq_q : run_irq_q;
      cnt_d     = load ? (guard_q == 8'd0 ? 8'd1 : guard_q) : state_q == DRAIN ? cnt_q - 8'd1 : cnt_q;
      active_d  = load ? '0 : engage ? (run_en_q ? ONE << run_sel_q : '0) : active_q;
      cur_sel_d = engage ? run_sel_q : cur_sel_q;
      valid_d   = engage ? run_en_q : valid_q;
      count_d   = engage ? count_q + 16'd1 : count_q;
      irq_d     = engage && run_irq_q;
   end
endmodule

// File: tb/tb_wrapped_project_select.sv
// tb_wrapped_project_select: scoreboard bench for the project scheduler; read
// expectations are queued at issue and retired when the ack returns data.
module tb_wrapped_project_select;
   localparam logic [31:0] BASE   = 32'h3000_0000;
   localparam logic [31:0] CTRL   = BASE;
   localparam logic [31:0] STATUS = BASE + 32'h4;
   localparam logic [31:0] GUARD  = BASE + 32'h8;
   localparam logic [31:0] COUNT  = BASE + 32'hC;
   typedef struct {string tag; logic [31:0] exp;} exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] active;
   logic       busy, irq;
   int         n_tests = 0;
   int         n_fail = 0;
   exp_t       sb[$];
   wrapped_project_select_if wb();
   wrapped_project_select #(.NUM_PROJECTS(8), .GUARD_RESET(4), .BASE_ADDR(BASE)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb(wb), .active_o(active), .busy_o(busy), .irq_o(irq));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic access(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input logic [3:0] sel, output logic acked, output logic [31:0] rdata);
      @(negedge clk);
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
      wb.wbs_we_i  = we;
      wb.wbs_sel_i = sel;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      acked = 1'b0;
      rdata = '0;
      for (int i = 0; i < 8 && !acked; i++) begin
         @(negedge clk);
         if (wb.wbs_ack_o) begin
            acked = 1'b1;
            rdata = wb.wbs_dat_o;
         end
      end
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask
   task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
      logic a;
      logic [31:0] d;
      access(adr, dat, 1'b1, sel, a, d);
      chk("wr_ack", 32'(a), 1);
   endtask
   task automatic rd(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      logic a;
      logic [31:0] d;
      exp_t e;
      sb.push_back('{tag, exp});
      access(adr, 32'h0, 1'b0, 4'hF, a, d);
      e = sb.pop_front();
      if (!a) chk({e.tag, "_ack"}, 0, 1);
      else chk(e.tag, d, e.exp);
   endtask
   // Call right after a CTRL write returns: g zero cycles, then the engage cycle, then idle
   task automatic run_seq(input string tag, input logic [7:0] exp_act, input int g, input logic exp_irq);
      for (int k = 0; k < g; k++) begin
         @(negedge clk);
         chk({tag, "_drain"}, {23'b0, busy, active}, {23'b0, 1'b1, 8'h00});
         chk({tag, "_drain_irq"}, 32'(irq), 0);
      end
      @(negedge clk);
      chk({tag, "_active"}, 32'(active), 32'(exp_act));
      chk({tag, "_irq"}, 32'(irq), 32'(exp_irq));
      chk({tag, "_busy_eng"}, 32'(busy), 1);
      @(negedge clk);
      chk({tag, "_busy_end"}, 32'(busy), 0);
      chk({tag, "_irq_end"}, 32'(irq), 0);
      chk({tag, "_hold"}, 32'(active), 32'(exp_act));
   endtask
   initial begin
      logic a, prev;
      logic [31:0] d;
      int pulses;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = 4'h0;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(wb.wbs_ack_o), 0);
      chk("rst_dat", wb.wbs_dat_o, 0);
      chk("rst_active", 32'(active), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_irq", 32'(irq), 0);
      rst = 1'b0;
      rd("rst_guard", GUARD, 32'd4);
      rd("rst_count", COUNT, 32'd0);
      rd("rst_ctrl", CTRL, 32'd0);
      rd("rst_status", STATUS, 32'd0);
      wr(CTRL, 32'h105);
      run_seq("basic", 8'h20, 4, 1'b0);
      rd("basic_status", STATUS, 32'h505);
      rd("basic_count", COUNT, 32'd1);
      rd("basic_ctrl", CTRL, 32'h105);
      wr(GUARD, 32'h55, 4'h0);
      rd("guard_sel_off", GUARD, 32'd4);
      wr(GUARD, 32'h0);
      rd("guard_zero", GUARD, 32'd0);
      wr(CTRL, 32'h302);
      run_seq("g0irq", 8'h04, 1, 1'b1);
      rd("g0_status", STATUS, 32'h502);
      wr(STATUS, 32'h400);
      rd("w1c_status", STATUS, 32'h102);
      rd("g0_count", COUNT, 32'd2);
      wr(GUARD, 32'h4);
      wr(CTRL, 32'h101);
      wr(CTRL, 32'h103);
      wr(CTRL, 32'h106);
      @(negedge clk);
      chk("pend_first", 32'(active), 32'h02);
      chk("pend_first_busy", 32'(busy), 1);
      run_seq("pend", 8'h40, 4, 1'b0);
      rd("pend_count", COUNT, 32'd4);
      wr(CTRL, 32'h000);
      run_seq("disable", 8'h00, 4, 1'b0);
      repeat (3) @(negedge clk);
      chk("disable_stays", 32'(active), 0);
      rd("disable_status", STATUS, 32'h400);
      rd("disable_count", COUNT, 32'd5);
      wr(CTRL, 32'h106);
      run_seq("same_a", 8'h40, 4, 1'b0);
      wr(CTRL, 32'h106);
      run_seq("same_b", 8'h40, 4, 1'b0);
      access(BASE + 32'h10, 32'h0, 1'b0, 4'hF, a, d);
      chk("unmapped_hi", 32'(a), 0);
      access(32'h4000_0000, 32'h0, 1'b1, 4'hF, a, d);
      chk("unmapped_other", 32'(a), 0);
      rd("unmapped_guard", GUARD, 32'd4);
      @(negedge clk);
      wb.wbs_adr_i = GUARD;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_cyc_i = 1'b1;
      pulses = 0;
      prev = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (wb.wbs_ack_o) pulses++;
         chk("b2b_gap", 32'(wb.wbs_ack_o & prev), 0);
         chk("b2b_dat", wb.wbs_dat_o, wb.wbs_ack_o ? 32'd4 : 32'd0);
         prev = wb.wbs_ack_o;
      end
      wb.wbs_stb_i = 1'b0;
      wb.wbs_cyc_i = 1'b0;
      chk("b2b_pulses", pulses, 3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_rst_active", 32'(active), 0);
      @(negedge clk);
      rst = 1'b0;
      wr(CTRL, 32'h101);
      @(negedge clk);
      chk("mid_drain_busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1 chk("mid_drain_rst", {23'b0, busy, active}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {23'b0, busy, active}, 0);
      rd("post_rst_guard", GUARD, 32'd4);
      rd("post_rst_count", COUNT, 32'd0);
      rd("post_rst_ctrl", CTRL, 32'd0);
      @(negedge clk);
      force dut.count_q = 16'hFFFF;
      #1 release dut.count_q;
      rd("wrap_pre", COUNT, 32'hFFFF);
      wr(CTRL, 32'h101);
      run_seq("wrap", 8'h02, 4, 1'b0);
      rd("wrap_post", COUNT, 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wrapped_project_select.md
# wrapped_project_select

Wishbone-programmable scheduler that decides which wrapped user project owns the shared pads, Wishbone and IRQ lines. It drives the one-hot `active` inputs of up to 16 wrapped projects. Switchover is break-before-make: the old project is deactivated, a programmable guard interval elapses, then the new project is activated. It sits in `user_project_wrapper` beside the wrapped projects and replaces the fixed `la_data_in[33]` activation.

## Interface
- `NUM_PROJECTS`, 8: number of projects; power of two, 2..16. `SEL_W = log2(NUM_PROJECTS)`.
- `GUARD_RESET`, 4: reset value of the GUARD register (cycles).
- `BASE_ADDR`, 32'h3000_0000: register block base; decode on `wbs_adr_i[31:4]`.

Ports:
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte enables; honoured on writes.
- `wbs_adr_i`, `wbs_dat_i`  in  32  address and write data.
- `wbs_ack_o`  out  1  acknowledge.
- `wbs_dat_o`  out  32  read data; 0 when not acking.
- `active_o`  out  NUM_PROJECTS  one-hot (or all-zero) project enables.
- `busy_o`  out  1  switch sequence in progress.
- `irq_o`  out  1  one-cycle completion pulse.

## Operation
- Registers, word offsets from BASE_ADDR:
  - 0x0 CTRL (RW): [SEL_W-1:0] target select, [8] enable, [9] irq enable. Reset 0.
  - 0x4 STATUS (RO except [10]): [SEL_W-1:0] current select, [8] active valid, [9] busy, [10] done (sticky; write 1 to clear).
  - 0x8 GUARD (RW): [7:0] guard cycles. Reset GUARD_RESET.
  - 0xC COUNT (RO): [15:0] completed sequences; wraps 0xFFFF→0.
- Reads of unused bits return 0. Writes to RO fields are ignored.
- Any CTRL write launches a sequence.
- FSM states: IDLE, DRAIN, ENGAGE.
  - IDLE → DRAIN on a CTRL write. `active_o` is forced to 0 and the guard counter is loaded with max(GUARD,1).
  - DRAIN: decrement the counter each cycle; on reaching 1, go to ENGAGE.
  - ENGAGE, one cycle: if enable=1, `active_o = 1<<select`; otherwise `active_o` stays 0. Set done, increment COUNT, pulse `irq_o` if irq enable=1, update STATUS current/valid, return to IDLE.
- A CTRL write while busy stores the new values as pending; only one pending request is held, and the last write wins. The current sequence completes normally, including its COUNT increment and irq. Next cycle the FSM enters DRAIN for the pending request.
- A CTRL write naming the same select already active with enable=1 still runs a full sequence. There is no short-cut, so software can force a project re-reset.
- GUARD writes take effect at the next DRAIN load. An in-flight count is unaffected.

## Timing
- Reset values: `wbs_ack_o=0`, `wbs_dat_o=0`, `active_o=0`, `busy_o=0`, `irq_o=0`, FSM=IDLE, pending cleared, COUNT=0. A reset mid-sequence drops `active_o` to 0 asynchronously.
- Wishbone:
  - The ack is registered. `wbs_ack_o` rises one cycle after `stb&cyc` with a matching address and the ack low, and is high for exactly one cycle.
  - Minimum 2 cycles per access.
  - Non-matching addresses are never acked.
  - The write commits on the edge that raises ack (edge T).
- CTRL write at edge T:
  - T+1: DRAIN, `active_o=0`, `busy_o=1`.
  - T+1+G': ENGAGE outputs are registered, where G' = max(GUARD,1). New `active_o`, done, COUNT+1 and `irq_o` all appear on that edge.
  - `busy_o` falls one cycle later.
  - `active_o` is all-zero for exactly G' cycles before a new project is enabled.
- A STATUS done-clear coinciding with done-set: the set wins.

## Test plan
- Reset: assert `wb_rst_i` mid-DRAIN → `active_o=0` asynchronously; after release, GUARD reads 4 and COUNT reads 0.
- Basic switch, GUARD=4: write CTRL=0x105 → `active_o`=0 for 4 cycles, then 8'h20; STATUS reads 0x505; COUNT=1.
- Irq and guard zero: GUARD=0, CTRL=0x302 → one-cycle DRAIN, `active_o`=8'h04, a single-cycle `irq_o` pulse; W1C of STATUS[10] clears done.
- Pending, last-wins: write CTRL=0x101, then 0x103, then 0x106 during DRAIN → `active_o` becomes 8'h02, then 0 for G' cycles, then 8'h40; COUNT +2.
- Disable: CTRL=0x000 while project 6 is active → `active_o` goes to 0 and stays 0; STATUS[8]=0, done=1.
- Wishbone: access an unmapped address → no ack; back-to-back stb → ack pulses separated by ≥1 low cycle. Preload COUNT to 0xFFFF with 65535 switches (or force) → wraps to 0.
